// File: rtl/llm_frontend_arbiter.sv
// Row-hit-aware round-robin arbiter feeding one registered command slot toward the
// backend DRAM controller; read returns are steered back in issue order via a tag FIFO.
module llm_frontend_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ROW_W     = 14,
    parameter int COL_W     = 4,
    parameter int DATA_W    = 128,
    parameter int TAG_DEPTH = 8,
    parameter int HIT_CAP   = 4
) (
    input  logic                        clk,
    input  logic                        power_on_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*ROW_W-1:0]    req_row,
    input  logic [NUM_REQ*COL_W-1:0]    req_col,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic                        o_cmd_valid,
    output logic                        o_cmd_op,
    output logic [ROW_W-1:0]            o_cmd_row,
    output logic [COL_W-1:0]            o_cmd_col,
    output logic [DATA_W-1:0]           o_cmd_wdata,
    input  logic                        i_backend_controller_ready,
    input  logic [DATA_W-1:0]           i_backend_read_data,
    input  logic                        i_backend_read_data_valid,
    output logic                        o_backend_controller_ren,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        err_orphan_read
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = $clog2(TAG_DEPTH);
    localparam int CW    = AW + 1;
    localparam int HW    = $clog2(HIT_CAP + 1);

    logic                cmd_valid_q;
    logic                cmd_op_q;
    logic [ROW_W-1:0]    cmd_row_q;
    logic [COL_W-1:0]    cmd_col_q;
    logic [DATA_W-1:0]   cmd_wdata_q;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]       hit_cnt_q, hit_cnt_d;
    logic                open_valid_q;
    logic [ROW_W-1:0]    open_row_q;
    logic [PTR_W-1:0]    tag_mem_q [TAG_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q;

    logic                slot_free;
    logic                fifo_nonempty;
    logic                fifo_full_eff;
    logic [PTR_W-1:0]    head;
    logic                rsp_fire;
    logic                ren;
    logic                push;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  hit;
    logic                found_rr, found_hit, use_hit, ooo_hit, grant;
    logic [PTR_W-1:0]    rr_idx, hit_idx, grant_idx, pos;
    logic                g_op;
    logic [ROW_W-1:0]    g_row;
    logic [COL_W-1:0]    g_col;
    logic [DATA_W-1:0]   g_wdata;

    assign slot_free     = !cmd_valid_q || i_backend_controller_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = tag_mem_q[rd_ptr_q];
    assign rsp_fire      = !power_on_rst && i_backend_read_data_valid && fifo_nonempty;
    assign ren           = rsp_fire && rsp_ready[head];
    // A pop this cycle frees a tag slot for a read granted in the same cycle.
    assign fifo_full_eff = (count_q == CW'(TAG_DEPTH)) && !ren;

    always_comb begin
        eligible = '0;
        hit      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !(req_op[i] && fifo_full_eff);
            hit[i]      = eligible[i] && open_valid_q &&
                          (req_row[i*ROW_W +: ROW_W] == open_row_q);
        end
    end

    always_comb begin
        found_rr  = 1'b0;
        found_hit = 1'b0;
        rr_idx    = '0;
        hit_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(rr_ptr_q) + k >= NUM_REQ) ? PTR_W'(int'(rr_ptr_q) + k - NUM_REQ)
                                                  : PTR_W'(int'(rr_ptr_q) + k);
            if (!found_rr && eligible[pos]) begin
                found_rr = 1'b1;
                rr_idx   = pos;
            end
            if (!found_hit && hit[pos]) begin
                found_hit = 1'b1;
                hit_idx   = pos;
            end
        end
    end

    assign use_hit   = found_hit && (hit_cnt_q < HW'(HIT_CAP));
    assign grant_idx = use_hit ? hit_idx : rr_idx;
    assign ooo_hit   = use_hit && (hit_idx != rr_idx);
    assign grant     = !power_on_rst && slot_free && found_rr;
    assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        g_op    = 1'b0;
        g_row   = '0;
        g_col   = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                g_op    = req_op[i];
                g_row   = req_row[i*ROW_W +: ROW_W];
                g_col   = req_col[i*COL_W +: COL_W];
                g_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign push     = grant && g_op;
    assign rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign hit_cnt_d = ooo_hit ? hit_cnt_q + HW'(1) : '0;

    always_comb begin
        count_d = count_q;
        case ({push, ren})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= 1'b0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            cmd_wdata_q  <= '0;
            rr_ptr_q     <= '0;
            hit_cnt_q    <= '0;
            open_valid_q <= 1'b0;
            open_row_q   <= '0;
        end else if (grant) begin
            cmd_valid_q  <= 1'b1;
            cmd_op_q     <= g_op;
            cmd_row_q    <= g_row;
            cmd_col_q    <= g_col;
            cmd_wdata_q  <= g_wdata;
            rr_ptr_q     <= rr_ptr_d;
            hit_cnt_q    <= hit_cnt_d;
            open_row_q   <= g_row;
            // The backend auto-precharges after the last column slot of a row.
            open_valid_q <= (g_col != {COL_W{1'b1}});
        end else if (i_backend_controller_ready) begin
            cmd_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (ren)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (i_backend_read_data_valid && !fifo_nonempty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
    end

    assign o_cmd_valid              = cmd_valid_q;
    assign o_cmd_op                 = cmd_op_q;
    assign o_cmd_row                = cmd_row_q;
    assign o_cmd_col                = cmd_col_q;
    assign o_cmd_wdata              = cmd_wdata_q;
    assign o_backend_controller_ren = ren;
    assign rsp_valid                = rsp_fire ? (NUM_REQ'(1) << head) : '0;
    assign rsp_data                 = i_backend_read_data;
    assign err_orphan_read          = err_q;

endmodule

// File: tb/tb_llm_frontend_arbiter.sv
// Directed bench for llm_frontend_arbiter: reset, round-robin, row-hit cap,
// auto-precharge, tag-FIFO full, response routing/backpressure, orphan reads.
module tb_llm_frontend_arbiter;

    localparam int N  = 4;
    localparam int RW = 14;
    localparam int CLW = 4;
    localparam int DW = 128;

    logic             clk;
    logic             power_on_rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_op;
    logic [N*RW-1:0]  req_row;
    logic [N*CLW-1:0] req_col;
    logic [N*DW-1:0]  req_wdata;
    logic             o_cmd_valid;
    logic             o_cmd_op;
    logic [RW-1:0]    o_cmd_row;
    logic [CLW-1:0]   o_cmd_col;
    logic [DW-1:0]    o_cmd_wdata;
    logic             i_backend_controller_ready;
    logic [DW-1:0]    i_backend_read_data;
    logic             i_backend_read_data_valid;
    logic             o_backend_controller_ren;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic             err_orphan_read;

    logic [RW-1:0]    row_a [N];
    logic [CLW-1:0]   col_a [N];
    logic [DW-1:0]    wd_a  [N];

    int errors = 0;
    int checks = 0;

    llm_frontend_arbiter dut (
        .clk                        (clk),
        .power_on_rst               (power_on_rst),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_op                     (req_op),
        .req_row                    (req_row),
        .req_col                    (req_col),
        .req_wdata                  (req_wdata),
        .o_cmd_valid                (o_cmd_valid),
        .o_cmd_op                   (o_cmd_op),
        .o_cmd_row                  (o_cmd_row),
        .o_cmd_col                  (o_cmd_col),
        .o_cmd_wdata                (o_cmd_wdata),
        .i_backend_controller_ready (i_backend_controller_ready),
        .i_backend_read_data        (i_backend_read_data),
        .i_backend_read_data_valid  (i_backend_read_data_valid),
        .o_backend_controller_ren   (o_backend_controller_ren),
        .rsp_valid                  (rsp_valid),
        .rsp_ready                  (rsp_ready),
        .rsp_data                   (rsp_data),
        .err_orphan_read            (err_orphan_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_row   = '0;
        req_col   = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_row[i*RW +: RW]    = row_a[i];
            req_col[i*CLW +: CLW]  = col_a[i];
            req_wdata[i*DW +: DW]  = wd_a[i];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic op,
                           input logic [RW-1:0] r, input logic [CLW-1:0] c);
        req_valid[i] = v;
        req_op[i]    = op;
        row_a[i]     = r;
        col_a[i]     = c;
    endtask

    initial begin
        power_on_rst               = 1'b1;
        i_backend_controller_ready = 1'b1;
        i_backend_read_data        = '0;
        i_backend_read_data_valid  = 1'b0;
        rsp_ready                  = '0;
        req_valid                  = '0;
        req_op                     = '0;
        for (int i = 0; i < N; i++) wd_a[i] = DW'(32'hC0DE_0000 + i);
        set_req(0, 1'b1, 1'b0, 14'h100, 4'hF);
        set_req(1, 1'b1, 1'b0, 14'h200, 4'hF);
        set_req(2, 1'b1, 1'b0, 14'h300, 4'hF);
        set_req(3, 1'b1, 1'b0, 14'h400, 4'hF);

        // Reset held three cycles with every requester valid.
        repeat (3) tick();
        chk("rst_cmd_valid", DW'(o_cmd_valid), 0);
        chk("rst_req_ready", DW'(req_ready), 0);
        chk("rst_rsp_valid", DW'(rsp_valid), 0);
        chk("rst_ren", DW'(o_backend_controller_ren), 0);
        chk("rst_err", DW'(err_orphan_read), 0);
        chk("rst_cmd_row", DW'(o_cmd_row), 0);
        chk("rst_cmd_wdata", o_cmd_wdata, 0);
        power_on_rst = 1'b0;
        #1;

        // Round robin over four writers (col 15 keeps no row open).
        chk("rr_ready0", DW'(req_ready), 4'b0001);
        tick();
        chk("rr_cmd0_valid", DW'(o_cmd_valid), 1);
        chk("rr_cmd0_row", DW'(o_cmd_row), 14'h100);
        chk("rr_cmd0_wdata", o_cmd_wdata, DW'(32'hC0DE_0000));
        chk("rr_ready1", DW'(req_ready), 4'b0010);
        tick();
        chk("rr_cmd1_row", DW'(o_cmd_row), 14'h200);
        chk("rr_ready2", DW'(req_ready), 4'b0100);
        tick();
        chk("rr_cmd2_row", DW'(o_cmd_row), 14'h300);
        chk("rr_ready3", DW'(req_ready), 4'b1000);
        tick();
        chk("rr_cmd3_row", DW'(o_cmd_row), 14'h400);
        chk("rr_cmd3_wdata", o_cmd_wdata, DW'(32'hC0DE_0003));
        chk("rr_ready4", DW'(req_ready), 4'b0001);
        tick();
        chk("rr_cmd4_row", DW'(o_cmd_row), 14'h100);
        req_valid = '0;
        #1;
        chk("rr_idle_ready", DW'(req_ready), 0);
        tick();
        chk("rr_drain_valid", DW'(o_cmd_valid), 0);

        // Row-hit streaming by requester 2, capped after four out-of-order grants.
        set_req(2, 1'b1, 1'b1, 14'h0A5, 4'h0);
        #1;
        chk("hit_open_ready", DW'(req_ready), 4'b0100);
        tick();
        chk("hit_open_op", DW'(o_cmd_op), 1);
        set_req(0, 1'b1, 1'b0, 14'h111, 4'h0);
        set_req(1, 1'b1, 1'b0, 14'h122, 4'h0);
        set_req(3, 1'b1, 1'b0, 14'h133, 4'h0);
        for (int c = 1; c <= 4; c++) begin
            col_a[2] = CLW'(c);
            #1;
            chk("hit_ooo_ready", DW'(req_ready), 4'b0100);
            tick();
            chk("hit_ooo_col", DW'(o_cmd_col), DW'(c));
        end
        col_a[2] = 4'h5;
        #1;
        chk("hit_cap_ready", DW'(req_ready), 4'b1000);
        tick();
        chk("hit_cap_row", DW'(o_cmd_row), 14'h133);
        req_valid[3] = 1'b0;
        #1;
        chk("hit_after_cap_ready", DW'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        tick();

        // Drain the five tags left by requester 2.
        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = DW'(128'hD0D0);
        rsp_ready                 = 4'b0100;
        #1;
        chk("drain2_rsp_valid", DW'(rsp_valid), 4'b0100);
        chk("drain2_rsp_data", rsp_data, DW'(128'hD0D0));
        for (int k = 0; k < 5; k++) begin
            chk("drain2_ren", DW'(o_backend_controller_ren), 1);
            tick();
        end
        i_backend_read_data_valid = 1'b0;
        rsp_ready = '0;
        #1;
        chk("drain2_done_rsp", DW'(rsp_valid), 0);
        chk("drain2_err", DW'(err_orphan_read), 0);

        // Auto-precharge: col 15 closes the row, so row 0x010 is not a hit afterwards.
        set_req(1, 1'b1, 1'b0, 14'h010, 4'hF);
        #1;
        chk("pre_ready", DW'(req_ready), 4'b0010);
        tick();
        chk("pre_cmd_col", DW'(o_cmd_col), 4'hF);
        set_req(1, 1'b1, 1'b0, 14'h010, 4'h0);
        set_req(3, 1'b1, 1'b0, 14'h333, 4'hF);
        #1;
        chk("pre_nohit_ready", DW'(req_ready), 4'b1000);
        tick();
        req_valid = '0;
        tick();

        // Tag FIFO full: eight reads, then only the write may go.
        set_req(0, 1'b1, 1'b1, 14'h500, 4'hF);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("full_fill_ready", DW'(req_ready), 4'b0001);
            tick();
        end
        set_req(1, 1'b1, 1'b0, 14'h600, 4'hF);
        #1;
        chk("full_write_ready", DW'(req_ready), 4'b0010);
        tick();
        chk("full_write_op", DW'(o_cmd_op), 0);
        req_valid[1] = 1'b0;
        #1;
        chk("full_stall_ready", DW'(req_ready), 0);
        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = DW'(128'hE0E0);
        rsp_ready                 = 4'b0001;
        #1;
        chk("full_pop_ren", DW'(o_backend_controller_ren), 1);
        chk("full_pop_ready", DW'(req_ready), 4'b0001);
        tick();
        i_backend_read_data_valid = 1'b0;
        #1;
        chk("full_again_ready", DW'(req_ready), 0);
        req_valid = '0;
        i_backend_read_data_valid = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        i_backend_read_data_valid = 1'b0;
        rsp_ready = '0;
        #1;
        chk("full_drain_err", DW'(err_orphan_read), 0);
        chk("full_drain_rsp", DW'(rsp_valid), 0);

        // Command slot held under backend stall, then reads by 3 then 1.
        i_backend_controller_ready = 1'b0;
        set_req(3, 1'b1, 1'b1, 14'h700, 4'hF);
        #1;
        chk("rt_ready3", DW'(req_ready), 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        set_req(1, 1'b1, 1'b1, 14'h710, 4'hF);
        #1;
        chk("stall_ready", DW'(req_ready), 0);
        tick();
        chk("stall_cmd_valid", DW'(o_cmd_valid), 1);
        chk("stall_cmd_row", DW'(o_cmd_row), 14'h700);
        i_backend_controller_ready = 1'b1;
        #1;
        chk("b2b_ready1", DW'(req_ready), 4'b0010);
        tick();
        chk("b2b_cmd_row", DW'(o_cmd_row), 14'h710);
        req_valid = '0;
        tick();

        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = DW'(128'h1111);
        rsp_ready                 = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_rsp_valid", DW'(rsp_valid), 4'b1000);
            chk("bp_ren", DW'(o_backend_controller_ren), 0);
            tick();
        end
        rsp_ready = 4'b1010;
        #1;
        chk("rt3_rsp_valid", DW'(rsp_valid), 4'b1000);
        chk("rt3_ren", DW'(o_backend_controller_ren), 1);
        chk("rt3_data", rsp_data, DW'(128'h1111));
        tick();
        i_backend_read_data = DW'(128'h2222);
        #1;
        chk("rt1_rsp_valid", DW'(rsp_valid), 4'b0010);
        chk("rt1_ren", DW'(o_backend_controller_ren), 1);
        tick();
        chk("orph_rsp_valid", DW'(rsp_valid), 0);
        chk("orph_ren", DW'(o_backend_controller_ren), 0);
        chk("orph_err_before", DW'(err_orphan_read), 0);
        tick();
        chk("orph_err_set", DW'(err_orphan_read), 1);
        i_backend_read_data_valid = 1'b0;
        rsp_ready = '0;
        tick();
        chk("orph_err_sticky", DW'(err_orphan_read), 1);

        // Reset mid-operation drops the held command and the outstanding tag.
        i_backend_controller_ready = 1'b0;
        set_req(2, 1'b1, 1'b1, 14'h800, 4'hF);
        #1;
        chk("mid_ready", DW'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        power_on_rst = 1'b1;
        #1;
        chk("mid_rst_cmd_valid", DW'(o_cmd_valid), 0);
        chk("mid_rst_err", DW'(err_orphan_read), 0);
        tick();
        power_on_rst = 1'b0;
        i_backend_controller_ready = 1'b1;
        i_backend_read_data_valid  = 1'b1;
        rsp_ready = 4'b1111;
        set_req(3, 1'b1, 1'b0, 14'h900, 4'h0);
        #1;
        chk("mid_after_rsp", DW'(rsp_valid), 0);
        chk("mid_after_ren", DW'(o_backend_controller_ren), 0);
        chk("mid_after_ready", DW'(req_ready), 4'b1000);
        i_backend_read_data_valid = 1'b0;
        req_valid = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
